powerup_controller: RTL

- Sequences the power-up feature for the Pong display path.
- After a random delay it spawns a power-up at a random on-screen position and makes it blink.
- It detects the ball touching the power-up, grants a timed effect (taller paddle, alternate colour) to the player who last hit the ball, then re-arms.
- It drives the display controller's power_en, power_pos_x/y, powerA/B, padA_h/padB_h and the shared blink signal.

---
 rtl/powerup_controller_pkg.sv | 29 ++
 rtl/powerup_controller_lfsr16.sv | 32 +++
 rtl/powerup_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/powerup_controller_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// powerup_controller_pkg : shared geometry, LFSR seed and FSM state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package powerup_controller_pkg;

  localparam logic [10:0] PU_W   = 11'd16;
  localparam logic [10:0] PU_H   = 11'd16;
  localparam logic [10:0] BALL_W = 11'd8;
  localparam logic [10:0] BALL_H = 11'd8;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SHOW   = 2'd2,
    ACTIVE = 2'd3
  } pu_state_e;

  // Strict 1-D overlap of [a, a+a_len) and [b, b+b_len); 11 bits so sums never wrap.
  function automatic logic overlap_1d(input logic [10:0] a, input logic [10:0] a_len,
                                      input logic [10:0] b, input logic [10:0] b_len);
    return (a < b + b_len) && (b < a + a_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/powerup_controller_lfsr16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lfsr16 : free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
// Rev 1.0
// ----------------------------------------------------------------------------
module lfsr16
  import powerup_controller_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Maximal-length polynomial with a non-zero seed never reaches the all-zero lockup.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/powerup_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// powerup_controller : spawns a blinking power-up, detects ball hits, grants
//                      a timed paddle/colour effect to the last hitter
// Rev 1.0
// ----------------------------------------------------------------------------
module powerup_controller
  import powerup_controller_pkg::*;
#(
  parameter int SPAWN_MIN     = 120,
  parameter int SHOW_FRAMES   = 300,
  parameter int EFFECT_FRAMES = 480,
  parameter int FLASH_FRAMES  = 15,
  parameter int PAD_H_NORM    = 64,
  parameter int PAD_H_BIG     = 96,
  parameter int PU_X_MIN      = 64,
  parameter int PU_Y_MIN      = 112
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       game_run,
  input  logic [9:0] x_ball,
  input  logic [9:0] y_ball,
  input  logic       ball_dir_x,
  output logic       power_en,
  output logic [9:0] power_pos_x,
  output logic [8:0] power_pos_y,
  output logic       powerA,
  output logic       powerB,
  output logic [7:0] padA_h,
  output logic [7:0] padB_h,
  output logic       flash
);

  localparam logic [9:0] C_SPAWN  = 10'(SPAWN_MIN);
  localparam logic [9:0] C_SHOW   = 10'(SHOW_FRAMES);
  localparam logic [9:0] C_EFFECT = 10'(EFFECT_FRAMES);
  localparam logic [9:0] C_FLAST  = 10'(FLASH_FRAMES - 1);
  localparam logic [9:0] C_XMIN   = 10'(PU_X_MIN);
  localparam logic [8:0] C_YMIN   = 9'(PU_Y_MIN);
  localparam logic [7:0] C_HNORM  = 8'(PAD_H_NORM);
  localparam logic [7:0] C_HBIG   = 8'(PAD_H_BIG);

  logic [15:0] lfsr;
  logic        hit;

  pu_state_e   state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  fcnt_q, fcnt_d;
  logic        flash_q, flash_d;
  logic        en_q, en_d;
  logic [9:0]  posx_q, posx_d;
  logic [8:0]  posy_q, posy_d;
  logic        pa_q, pa_d;
  logic        pb_q, pb_d;
  logic [7:0]  ha_q, ha_d;
  logic [7:0]  hb_q, hb_d;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );

  assign hit = overlap_1d({1'b0, x_ball}, BALL_W, {1'b0, posx_q}, PU_W) &&
               overlap_1d({1'b0, y_ball}, BALL_H, {2'b00, posy_q}, PU_H);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    flash_d = flash_q;
    en_d    = en_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    ha_d    = ha_q;
    hb_d    = hb_q;

    if (frame_tick) begin
      if (fcnt_q == C_FLAST) begin
        fcnt_d  = '0;
        flash_d = ~flash_q;
      end else begin
        fcnt_d = fcnt_q + 10'd1;
      end

      // Losing the rally overrides everything else, including a same-tick hit.
      if (!game_run) begin
        state_d = IDLE;
        en_d    = 1'b0;
        pa_d    = 1'b0;
        pb_d    = 1'b0;
        ha_d    = C_HNORM;
        hb_d    = C_HNORM;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_d   = C_SPAWN + {4'd0, lfsr[5:0]};
            state_d = WAIT;
          end
          WAIT: begin
            if (cnt_q == '0) begin
              posx_d  = C_XMIN + {1'b0, lfsr[7:0], 1'b0};
              posy_d  = C_YMIN + {1'b0, lfsr[15:8]};
              cnt_d   = C_SHOW;
              en_d    = 1'b1;
              state_d = SHOW;
            end else begin
              cnt_d = cnt_q - 10'd1;
            end
          end
          SHOW: begin
            if (hit) begin
              en_d = 1'b0;
              if (ball_dir_x) begin
                pa_d = 1'b1;
                ha_d = C_HBIG;
              end else begin
                pb_d = 1'b1;
                hb_d = C_HBIG;
              end
              cnt_d   = C_EFFECT;
              state_d = ACTIVE;
            end else if (cnt_q == '0) begin
              en_d    = 1'b0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q - 10'd1;
            end
          end
          ACTIVE: begin
            if (cnt_q == '0) begin
              pa_d    = 1'b0;
              pb_d    = 1'b0;
              ha_d    = C_HNORM;
              hb_d    = C_HNORM;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q - 10'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      flash_q <= 1'b1;
      en_q    <= 1'b0;
      posx_q  <= '0;
      posy_q  <= '0;
      pa_q    <= 1'b0;
      pb_q    <= 1'b0;
      ha_q    <= C_HNORM;
      hb_q    <= C_HNORM;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      flash_q <= flash_d;
      en_q    <= en_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      ha_q    <= ha_d;
      hb_q    <= hb_d;
    end
  end

  assign power_en    = en_q;
  assign power_pos_x = posx_q;
  assign power_pos_y = posy_q;
  assign powerA      = pa_q;
  assign powerB      = pb_q;
  assign padA_h      = ha_q;
  assign padB_h      = hb_q;
  assign flash       = flash_q;

endmodule
`default_nettype wire
